// File: rtl/tmu2_fetchsched.sv
// Texture-unit fetch scheduler: registers each pipeline request and, for every missing
// texel line, reads the 4-beat line over FML and writes it into the texel cache before releasing the request.
module tmu2_fetchsched #(
    parameter int cache_depth = 13,
    parameter int fml_depth   = 26
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    output logic                   busy,

    input  logic                   pipe_stb_i,
    output logic                   pipe_ack_o,
    input  logic [fml_depth-2:0]   dadr,
    input  logic [fml_depth-1:0]   tadra,
    input  logic [fml_depth-1:0]   tadrb,
    input  logic [fml_depth-1:0]   tadrc,
    input  logic [fml_depth-1:0]   tadrd,
    input  logic [5:0]             x_frac,
    input  logic [5:0]             y_frac,
    input  logic                   miss_a,
    input  logic                   miss_b,
    input  logic                   miss_c,
    input  logic                   miss_d,

    output logic                   pipe_stb_o,
    input  logic                   pipe_ack_i,
    output logic [fml_depth-2:0]   dadr_f,
    output logic [fml_depth-1:0]   tadra_f,
    output logic [fml_depth-1:0]   tadrb_f,
    output logic [fml_depth-1:0]   tadrc_f,
    output logic [fml_depth-1:0]   tadrd_f,
    output logic [5:0]             x_frac_f,
    output logic [5:0]             y_frac_f,

    output logic [fml_depth-1:0]   fml_adr,
    output logic                   fml_stb,
    input  logic                   fml_ack,
    input  logic [63:0]            fml_di,

    output logic                   cache_we,
    output logic [cache_depth-4:0] cache_wa,
    output logic [63:0]            cache_wd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int line_w = fml_depth - 5;

    // Fixed priority a > b > c > d over the pending-line mask.
    function automatic logic [1:0] first_pending(input logic [3:0] p);
        if (p[0]) begin
            return 2'd0;
        end else if (p[1]) begin
            return 2'd1;
        end else if (p[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    function automatic logic [line_w-1:0] pick_line(
        input logic [1:0]        sel,
        input logic [line_w-1:0] a,
        input logic [line_w-1:0] b,
        input logic [line_w-1:0] c,
        input logic [line_w-1:0] d
    );
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return d;
        endcase
    endfunction

    state_t            state;
    logic [3:0]        pending;
    logic [1:0]        beat;
    logic [1:0]        sel;
    logic [3:0]        remaining;
    logic [3:0]        miss_vec;
    logic [line_w-1:0] cur_line;
    logic              accept;

    assign miss_vec   = {miss_d, miss_c, miss_b, miss_a};
    assign pipe_ack_o = (state == IDLE) & (~pipe_stb_o | pipe_ack_i);
    assign accept     = pipe_stb_i & pipe_ack_o;
    assign busy       = (state != IDLE) | pipe_stb_o;

    // The line being served is selected from registered state only, so address and index stay stable.
    assign sel       = first_pending(pending);
    assign remaining = pending & ~(4'b0001 << sel);
    assign cur_line  = pick_line(sel, tadra_f[fml_depth-1:5], tadrb_f[fml_depth-1:5],
                                 tadrc_f[fml_depth-1:5], tadrd_f[fml_depth-1:5]);
    assign fml_adr   = {cur_line, 5'b00000};
    assign cache_wa  = {cur_line[cache_depth-6:0], beat};
    assign cache_wd  = fml_di;

    // Control FSM: request hand-off, line fetch request and burst beat tracking.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            pending    <= 4'b0000;
            beat       <= 2'd0;
            pipe_stb_o <= 1'b0;
            fml_stb    <= 1'b0;
            cache_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pending <= miss_vec;
                        if (|miss_vec) begin
                            pipe_stb_o <= 1'b0;
                            fml_stb    <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            pipe_stb_o <= 1'b1;
                        end
                    end else if (pipe_ack_i) begin
                        pipe_stb_o <= 1'b0;
                    end
                end
                FETCH: begin
                    if (fml_ack) begin
                        fml_stb  <= 1'b0;
                        cache_we <= 1'b1;
                        beat     <= 2'd0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    beat <= beat + 2'd1;
                    if (beat == 2'd3) begin
                        cache_we <= 1'b0;
                        pending  <= remaining;
                        if (|remaining) begin
                            fml_stb <= 1'b1;
                            state   <= FETCH;
                        end else begin
                            pipe_stb_o <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    pending    <= 4'b0000;
                    pipe_stb_o <= 1'b0;
                    fml_stb    <= 1'b0;
                    cache_we   <= 1'b0;
                end
            endcase
        end
    end

    // Request registers carry no reset: they are only meaningful once loaded by an accept.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            dadr_f   <= dadr;
            tadra_f  <= tadra;
            tadrb_f  <= tadrb;
            tadrc_f  <= tadrc;
            tadrd_f  <= tadrd;
            x_frac_f <= x_frac;
            y_frac_f <= y_frac;
        end
    end

endmodule

// File: tb/tb_tmu2_fetchsched.sv
// Bench for tmu2_fetchsched: a queue-based model of requests, line fetches and bursts,
// checked every cycle on the falling edge, plus literal expectations for directed scenarios.
module tb_tmu2_fetchsched;

    localparam int CD = 13;
    localparam int FD = 26;

    typedef struct packed {
        logic [FD-2:0] dadr;
        logic [FD-1:0] ta;
        logic [FD-1:0] tb;
        logic [FD-1:0] tc;
        logic [FD-1:0] td;
        logic [5:0]    xf;
        logic [5:0]    yf;
    } req_t;

    typedef struct {
        logic [FD-1:0] adr;
        logic [CD-6:0] idx;
    } line_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic busy, pipe_stb_i, pipe_ack_o, pipe_stb_o, pipe_ack_i;
    logic [FD-2:0] dadr, dadr_f;
    logic [FD-1:0] tadra, tadrb, tadrc, tadrd, tadra_f, tadrb_f, tadrc_f, tadrd_f;
    logic [5:0] x_frac, y_frac, x_frac_f, y_frac_f;
    logic miss_a, miss_b, miss_c, miss_d;
    logic [FD-1:0] fml_adr;
    logic fml_stb, fml_ack, cache_we;
    logic [63:0] fml_di, cache_wd;
    logic [CD-4:0] cache_wa;
    req_t got_out;

    assign got_out = {dadr_f, tadra_f, tadrb_f, tadrc_f, tadrd_f, x_frac_f, y_frac_f};

    tmu2_fetchsched #(.cache_depth(CD), .fml_depth(FD)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .busy(busy),
        .pipe_stb_i(pipe_stb_i), .pipe_ack_o(pipe_ack_o),
        .dadr(dadr), .tadra(tadra), .tadrb(tadrb), .tadrc(tadrc), .tadrd(tadrd),
        .x_frac(x_frac), .y_frac(y_frac),
        .miss_a(miss_a), .miss_b(miss_b), .miss_c(miss_c), .miss_d(miss_d),
        .pipe_stb_o(pipe_stb_o), .pipe_ack_i(pipe_ack_i),
        .dadr_f(dadr_f), .tadra_f(tadra_f), .tadrb_f(tadrb_f), .tadrc_f(tadrc_f), .tadrd_f(tadrd_f),
        .x_frac_f(x_frac_f), .y_frac_f(y_frac_f),
        .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_ack(fml_ack), .fml_di(fml_di),
        .cache_we(cache_we), .cache_wa(cache_wa), .cache_wd(cache_wd)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_req(input string name, input req_t act, input req_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // FML slave: acks after ack_delay stalled cycles, then streams 4 tagged beats.
    int ack_delay = 0;
    int wait_cnt  = 0;
    int beat_left = 0;
    int burst_no  = 0;

    initial begin
        fml_ack = 1'b0;
        fml_di  = 64'd0;
        forever begin
            @(posedge sys_clk);
            #1;
            fml_ack = 1'b0;
            if (sys_rst) begin
                beat_left = 0;
                wait_cnt  = 0;
            end else if (beat_left > 0) begin
                fml_di = {32'hC0DE0000 | 32'(burst_no), 32'(4 - beat_left)};
                beat_left--;
            end else if (fml_stb) begin
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    fml_ack   = 1'b1;
                    wait_cnt  = 0;
                    beat_left = 4;
                    burst_no++;
                end
            end
        end
    end

    // Model state and scenario logs.
    line_t         fq[$];
    req_t          m_out, m_held;
    bit            m_valid = 1'b0;
    int            m_burst = 0;
    int            m_beat = 0;
    int            m_fetch_no = 0;
    logic [CD-6:0] m_idx = '0;

    int cyc = 0, stbo_cnt = 0, stbo_first = 0, stbo_last = 0;
    int stb_cnt = 0, we_cnt = 0, we_last = 0, acc_cnt = 0;
    logic [FD-1:0] adr_log[$];
    logic [CD-4:0] wa_log[$];

    task automatic clear_logs();
        stbo_cnt = 0; stbo_first = 0; stbo_last = 0;
        stb_cnt = 0; we_cnt = 0; we_last = 0; acc_cnt = 0;
        adr_log.delete();
        wa_log.delete();
    endtask

    // Compare process: check this cycle against the model, then advance the model.
    always @(negedge sys_clk) begin
        bit            fetching, e_ack, e_stb, acc;
        req_t          req;
        logic [3:0]    mv;
        logic [FD-1:0] tv[4];
        line_t         ln;
        cyc++;
        if (sys_rst) begin
            chk("rst_pipe_stb_o", 64'(pipe_stb_o), 64'd0);
            chk("rst_fml_stb", 64'(fml_stb), 64'd0);
            chk("rst_cache_we", 64'(cache_we), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_pipe_ack_o", 64'(pipe_ack_o), 64'd1);
            fq.delete();
            m_burst = 0;
            m_valid = 1'b0;
        end else begin
            fetching = (fq.size() != 0) || (m_burst != 0);
            e_ack    = !fetching && (!m_valid || pipe_ack_i);
            e_stb    = (fq.size() != 0) && (m_burst == 0);
            chk("pipe_ack_o", 64'(pipe_ack_o), 64'(e_ack));
            chk("busy", 64'(busy), 64'(fetching || m_valid));
            chk("pipe_stb_o", 64'(pipe_stb_o), 64'(m_valid));
            chk("fml_stb", 64'(fml_stb), 64'(e_stb));
            chk("cache_we", 64'(cache_we), 64'(m_burst != 0));
            if (m_valid) chk_req("out_regs", got_out, m_out);
            if (e_stb && fml_stb) chk("fml_adr", 64'(fml_adr), 64'(fq[0].adr));
            if (m_burst != 0 && cache_we) begin
                chk("cache_wa", 64'(cache_wa), 64'({m_idx, 2'(m_beat)}));
                chk("cache_wd", cache_wd, {32'hC0DE0000 | 32'(m_fetch_no), 32'(m_beat)});
            end

            if (pipe_stb_o) begin
                if (stbo_cnt == 0) stbo_first = cyc;
                stbo_last = cyc;
                stbo_cnt++;
            end
            if (fml_stb) stb_cnt++;
            if (fml_stb && fml_ack) adr_log.push_back(fml_adr);
            if (cache_we) begin
                we_cnt++;
                we_last = cyc;
                wa_log.push_back(cache_wa);
            end

            acc = pipe_stb_i && e_ack;
            if (acc) begin
                req = {dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac};
                mv  = {miss_d, miss_c, miss_b, miss_a};
                tv  = '{tadra, tadrb, tadrc, tadrd};
                acc_cnt++;
                if (mv != 4'b0000) begin
                    m_valid = 1'b0;
                    m_held  = req;
                    for (int i = 0; i < 4; i++) begin
                        if (mv[i]) begin
                            ln.adr = FD'((tv[i] >> 5) << 5);
                            ln.idx = (CD-5)'(tv[i] >> 5);
                            fq.push_back(ln);
                        end
                    end
                end else begin
                    m_valid = 1'b1;
                    m_out   = req;
                end
            end else if (pipe_ack_i) begin
                m_valid = 1'b0;
            end

            if (m_burst != 0) begin
                m_burst--;
                m_beat++;
                if (m_burst == 0 && fq.size() == 0) begin
                    m_valid = 1'b1;
                    m_out   = m_held;
                end
            end else if (e_stb && fml_ack) begin
                m_idx = fq[0].idx;
                void'(fq.pop_front());
                m_burst = 4;
                m_beat  = 0;
                m_fetch_no++;
            end
        end
    end

    function automatic req_t mk(input int n, input logic [FD-1:0] ta, input logic [FD-1:0] tb,
                                input logic [FD-1:0] tc, input logic [FD-1:0] td);
        req_t r;
        r.dadr = (FD-1)'(n * 7 + 1);
        r.ta = ta; r.tb = tb; r.tc = tc; r.td = td;
        r.xf = 6'(n);
        r.yf = 6'(63 - n);
        return r;
    endfunction

    // Present a request from posedge+1 until accepted; returns at posedge+1 after the accept edge.
    task automatic send(input req_t r, input logic [3:0] mv);
        pipe_stb_i = 1'b1;
        {dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac} = r;
        {miss_d, miss_c, miss_b, miss_a} = mv;
        for (int t = 0; t < 300; t++) begin
            @(negedge sys_clk);
            if (pipe_ack_o) break;
            if (t == 299) chk("accept_timeout", 64'd0, 64'd1);
        end
        @(posedge sys_clk);
        #1;
        pipe_stb_i = 1'b0;
        {miss_d, miss_c, miss_b, miss_a} = 4'b0000;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 300; t++) begin
            @(negedge sys_clk);
            if (!busy) break;
            if (t == 299) chk("idle_timeout", 64'(busy), 64'd0);
        end
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        pipe_stb_i = 1'b0; pipe_ack_i = 1'b1;
        dadr = '0; tadra = '0; tadrb = '0; tadrc = '0; tadrd = '0;
        x_frac = '0; y_frac = '0;
        {miss_d, miss_c, miss_b, miss_a} = 4'b0000;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("ack_first_cycle", 64'(pipe_ack_o), 64'd1);
        @(posedge sys_clk);
        #1;

        // Hit stream, then miss flags without a strobe must be ignored.
        clear_logs();
        for (int i = 0; i < 8; i++)
            send(mk(i, FD'(i * 32), FD'(i * 64), FD'(i * 96), FD'(i * 128)), 4'b0000);
        {miss_d, miss_c, miss_b, miss_a} = 4'b1111;
        repeat (3) @(posedge sys_clk);
        #1 {miss_d, miss_c, miss_b, miss_a} = 4'b0000;
        wait_idle();
        chk("hit_outputs", 64'(stbo_cnt), 64'd8);
        chk("hit_consecutive", 64'(stbo_last - stbo_first), 64'd7);
        chk("hit_no_fml", 64'(stb_cnt), 64'd0);
        chk("hit_accepts", 64'(acc_cnt), 64'd8);

        // Single miss on channel b.
        clear_logs();
        send(mk(10, 26'h0000040, 26'h0123460, 26'h0000080, 26'h00000C0), 4'b0010);
        wait_idle();
        chk("b_fetches", 64'(adr_log.size()), 64'd1);
        if (adr_log.size() == 1) chk("b_fml_adr", 64'(adr_log[0]), 64'h0123460);
        chk("b_we_count", 64'(wa_log.size()), 64'd4);
        if (wa_log.size() == 4) begin
            chk("b_wa_first", 64'(wa_log[0]), 64'h28C);
            chk("b_wa_last", 64'(wa_log[3]), 64'h28F);
        end
        chk("b_release_once", 64'(stbo_cnt), 64'd1);
        chk("b_release_timing", 64'(stbo_first), 64'(we_last + 1));

        // All four channels miss: fetched in order a, b, c, d.
        clear_logs();
        send(mk(11, 26'h0000020, 26'h1000040, 26'h2ABCDE0, 26'h3FFFFFF), 4'b1111);
        wait_idle();
        chk("all_fetches", 64'(adr_log.size()), 64'd4);
        if (adr_log.size() == 4) begin
            chk("all_adr_a", 64'(adr_log[0]), 64'h0000020);
            chk("all_adr_b", 64'(adr_log[1]), 64'h1000040);
            chk("all_adr_c", 64'(adr_log[2]), 64'h2ABCDE0);
            chk("all_adr_d", 64'(adr_log[3]), 64'h3FFFFE0);
        end
        chk("all_we_count", 64'(we_cnt), 64'd16);
        if (wa_log.size() == 16) begin
            chk("all_wa_first", 64'(wa_log[0]), 64'h004);
            chk("all_wa_last", 64'(wa_log[15]), 64'h3FF);
        end
        chk("all_release_once", 64'(stbo_cnt), 64'd1);
        chk("all_release_timing", 64'(stbo_first), 64'(we_last + 1));

        // FML ack held off for 10 cycles.
        ack_delay = 10;
        clear_logs();
        send(mk(12, 26'h0000000, 26'h0000000, 26'h0155500, 26'h0000000), 4'b0100);
        wait_idle();
        ack_delay = 0;
        chk("slow_stb_cycles", 64'(stb_cnt), 64'd11);
        chk("slow_we_count", 64'(we_cnt), 64'd4);
        if (adr_log.size() == 1) chk("slow_fml_adr", 64'(adr_log[0]), 64'h0155500);

        // Downstream stall with a waiting request.
        pipe_ack_i = 1'b0;
        clear_logs();
        send(mk(20, 26'h1, 26'h2, 26'h3, 26'h4), 4'b0000);
        pipe_stb_i = 1'b1;
        {dadr, tadra, tadrb, tadrc, tadrd, x_frac, y_frac} = mk(21, 26'h5, 26'h6, 26'h7, 26'h8);
        repeat (5) begin
            @(negedge sys_clk);
            chk("stall_ack_o", 64'(pipe_ack_o), 64'd0);
            chk("stall_stb_o", 64'(pipe_stb_o), 64'd1);
        end
        @(posedge sys_clk);
        #1 pipe_ack_i = 1'b1;
        @(negedge sys_clk);
        chk("stall_release_ack", 64'(pipe_ack_o), 64'd1);
        @(posedge sys_clk);
        #1 pipe_stb_i = 1'b0;
        wait_idle();
        chk("stall_accepts", 64'(acc_cnt), 64'd2);
        chk("stall_stb_cycles", 64'(stbo_cnt), 64'd7);

        // Reset during beat 2 of a burst, then a normal miss request.
        clear_logs();
        send(mk(30, 26'h0000100, 26'h0, 26'h0, 26'h0), 4'b0001);
        for (int t = 0; t < 100; t++) begin
            @(negedge sys_clk);
            if (we_cnt >= 2) break;
        end
        @(posedge sys_clk);
        #1 chk("beat2_we_before_rst", 64'(cache_we), 64'd1);
        #1 sys_rst = 1'b1;
        #1;
        chk("rst_now_we", 64'(cache_we), 64'd0);
        chk("rst_now_fml_stb", 64'(fml_stb), 64'd0);
        chk("rst_now_busy", 64'(busy), 64'd0);
        @(posedge sys_clk);
        #3 sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        clear_logs();
        send(mk(31, 26'h0, 26'h0000200, 26'h0, 26'h0), 4'b0010);
        wait_idle();
        chk("post_rst_we_count", 64'(we_cnt), 64'd4);
        chk("post_rst_release", 64'(stbo_cnt), 64'd1);
        if (adr_log.size() == 1) chk("post_rst_fml_adr", 64'(adr_log[0]), 64'h0000200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
